// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the register_file_mp register file: default word
// width, address-width helper and the default-configuration word/address types.
package rf_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  // Register address width for an n-entry file (at least one bit).
  function automatic int AW_OF(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [AW_OF(NREGS_DEFAULT)-1:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0]         xword_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave):
// packed read ports, packed write ports, the reservation request and BusyCount.
interface register_file_mp_if import rf_pkg::*; #(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) ();

  localparam int AW = AW_OF(NREGS);

  logic [NREAD*AW-1:0]     ReadRegister;
  logic [NREAD*XLEN-1:0]   ReadData;
  logic [NREAD-1:0]        ReadBusy;
  logic [NWRITE-1:0]       WriteEnable;
  logic [NWRITE*AW-1:0]    WriteRegister;
  logic [NWRITE*XLEN-1:0]  WriteData;
  logic                    ReserveValid;
  logic [AW-1:0]           ReserveRegister;
  logic                    ReserveAccept;
  logic [AW:0]             BusyCount;

  modport master (
    output ReadRegister, WriteEnable, WriteRegister, WriteData,
           ReserveValid, ReserveRegister,
    input  ReadData, ReadBusy, ReserveAccept, BusyCount
  );

  modport slave (
    input  ReadRegister, WriteEnable, WriteRegister, WriteData,
           ReserveValid, ReserveRegister,
    output ReadData, ReadBusy, ReserveAccept, BusyCount
  );

endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Busy scoreboard: one bit per register marking an in-flight producer.
// Reservations set bits, writes clear them; a same-cycle set beats a clear
// because the reservation belongs to a newer producer. busy[0] is never set.
module rf_scoreboard import rf_pkg::*; #(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NREAD = 2,
  localparam int AW    = AW_OF(NREGS)
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                set_valid_i,
  input  logic [AW-1:0]       set_addr_i,
  input  logic [NREGS-1:0]    clear_vec_i,
  input  logic [NREAD*AW-1:0] query_addr_i,
  output logic [NREAD-1:0]    query_busy_o,
  output logic                set_accept_o,
  output logic [AW:0]         busy_count_o
);

  localparam int CW = AW + 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    count_q, count_d;

  // A reservation is granted only against the pre-edge busy bit (WAW stall).
  assign set_accept_o = set_valid_i & ~busy_q[set_addr_i];

  // Next busy vector: clear on write, then set on an accepted reservation.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    busy_d = busy_q & ~clear_vec_i;
    if (set_accept_o && (set_addr_i != '0)) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    count_d   = '0;
    for (int r = 0; r < NREGS; r++) begin
      count_d = count_d + CW'(busy_d[r]);
    end
  end

  // Busy bits and their population count, both discarded by reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Busy lookup for each read port.
  always_comb begin
    query_busy_o = '0;
    for (int i = 0; i < NREAD; i++) begin
      query_busy_o[i] = busy_q[query_addr_i[i*AW +: AW]];
    end
  end

  assign busy_count_o = count_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with busy scoreboard; x0 reads as zero.
// Optional macro BYPASS_EN forwards same-cycle write data to the read ports
// and masks the matching busy flag; without it, reads see pre-edge state.
module register_file_mp import rf_pkg::*; #(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 2
) (
  input  logic                Clock,
  input  logic                ResetN,
  register_file_mp_if.slave   bus
);

  localparam int AW = AW_OF(NREGS);

  logic [XLEN-1:0]  data_q [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREAD-1:0] sb_busy;

  // Per-register write selection: the highest-index enabled port wins; x0 is never hit.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      wr_val[r] = '0;
      for (int w = 0; w < NWRITE; w++) begin
        if ((r != 0) && bus.WriteEnable[w] &&
            (bus.WriteRegister[w*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = bus.WriteData[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Register array update; x0 is only ever loaded with zero.
  // NOTE: the array is reset because every register must read zero right after reset.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int r = 0; r < NREGS; r++) begin
        data_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          data_q[r] <= wr_val[r];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_scoreboard (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .set_valid_i  (bus.ReserveValid),
    .set_addr_i   (bus.ReserveRegister),
    .clear_vec_i  (wr_hit),
    .query_addr_i (bus.ReadRegister),
    .query_busy_o (sb_busy),
    .set_accept_o (bus.ReserveAccept),
    .busy_count_o (bus.BusyCount)
  );

  // Read ports: zero-latency array lookup, optionally forwarding the winning write.
  always_comb begin
    bus.ReadData = '0;
    bus.ReadBusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.ReadData[i*XLEN +: XLEN] = data_q[bus.ReadRegister[i*AW +: AW]];
      bus.ReadBusy[i]              = sb_busy[i];
`ifdef BYPASS_EN
      if (wr_hit[bus.ReadRegister[i*AW +: AW]]) begin
        bus.ReadData[i*XLEN +: XLEN] = wr_val[bus.ReadRegister[i*AW +: AW]];
        bus.ReadBusy[i]              = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed testbench for register_file_mp (default 64x32, 2 read, 2 write ports).
// Expectations that depend on BYPASS_EN follow the same macro.
module tb_register_file_mp;
  import rf_pkg::*;

  localparam int XLEN   = 64;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

`ifdef BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) bus ();

  register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.WriteEnable     = '0;
    bus.WriteRegister   = '0;
    bus.WriteData       = '0;
    bus.ReserveValid    = 1'b0;
    bus.ReserveRegister = '0;
  endtask

  task automatic set_read(input int p, input reg_addr_t a);
    bus.ReadRegister[p*AW +: AW] = a;
  endtask

  task automatic set_write(input int p, input reg_addr_t a, input xword_t d);
    bus.WriteEnable[p]              = 1'b1;
    bus.WriteRegister[p*AW +: AW]   = a;
    bus.WriteData[p*XLEN +: XLEN]   = d;
  endtask

  task automatic set_reserve(input reg_addr_t a);
    bus.ReserveValid    = 1'b1;
    bus.ReserveRegister = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic xword_t rd(input int p);
    return bus.ReadData[p*XLEN +: XLEN];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    // power-on state while reset is held
    set_read(0, 5'd5);
    set_read(1, 5'd0);
    #1;
    tests_run++;
    if (rd(0) !== 64'h0 || rd(1) !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h expected 0/0", rd(0), rd(1));
    end
    tests_run++;
    if (bus.ReadBusy !== 2'b00 || bus.BusyCount !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_busy: busy %b count %0d expected 00/0", bus.ReadBusy, bus.BusyCount);
    end
    #11 rst_n = 1'b1;
    step();
    // load x5 and reserve x6, then reset mid-cycle
    set_write(0, 5'd5, 64'h55);
    set_reserve(5'd6);
    step();
    idle_inputs();
    step();
    set_read(0, 5'd5);
    set_read(1, 5'd6);
    #1;
    tests_run++;
    if (rd(0) !== 64'h55 || bus.ReadBusy[1] !== 1'b1 || bus.BusyCount !== 6'd1) begin
      tests_failed++;
      $display("FAIL premid_state: x5 %h busy6 %b count %0d expected 55/1/1", rd(0), bus.ReadBusy[1], bus.BusyCount);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rd(0) !== 64'h0 || bus.ReadBusy !== 2'b00 || bus.BusyCount !== 6'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset: x5 %h busy %b count %0d expected 0/00/0", rd(0), bus.ReadBusy, bus.BusyCount);
    end
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_port0();
    set_write(0, 5'd5, 64'hDEAD_BEEF);
    set_read(0, 5'd5);
    #1;
    tests_run++;
    if (rd(0) !== (BYP ? 64'hDEAD_BEEF : 64'h0)) begin
      tests_failed++;
      $display("FAIL write_same_cycle_x5: got %h expected %h", rd(0), (BYP ? 64'hDEAD_BEEF : 64'h0));
    end
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (rd(0) !== 64'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_p0_x5: got %h expected deadbeef", rd(0));
    end
    set_write(1, 5'd0, 64'h1);
    set_read(1, 5'd0);
    #1;
    tests_run++;
    if (rd(1) !== 64'h0) begin
      tests_failed++;
      $display("FAIL x0_same_cycle: got %h expected 0", rd(1));
    end
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (rd(1) !== 64'h0) begin
      tests_failed++;
      $display("FAIL x0_write_ignored: got %h expected 0", rd(1));
    end
  endtask

  task automatic test_priority();
    set_write(0, 5'd7, 64'h11);
    set_write(1, 5'd7, 64'h22);
    step();
    idle_inputs();
    set_write(1, 5'd8, 64'h44);
    set_write(0, 5'd8, 64'h55);
    step();
    idle_inputs();
    set_read(0, 5'd7);
    set_read(1, 5'd8);
    #1;
    tests_run++;
    if (rd(0) !== 64'h22) begin
      tests_failed++;
      $display("FAIL priority_x7: got %h expected 22", rd(0));
    end
    tests_run++;
    if (rd(1) !== 64'h44) begin
      tests_failed++;
      $display("FAIL priority_x8: got %h expected 44", rd(1));
    end
  endtask

  task automatic test_reserve();
    set_read(0, 5'd3);
    set_reserve(5'd3);
    #1;
    tests_run++;
    if (bus.ReserveAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL reserve_x3_accept: got %b expected 1", bus.ReserveAccept);
    end
    step();
    idle_inputs();
    step();
    tests_run++;
    if (bus.BusyCount !== 6'd1 || bus.ReadBusy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reserve_x3_busy: count %0d busy %b expected 1/1", bus.BusyCount, bus.ReadBusy[0]);
    end
    set_reserve(5'd3);
    #1;
    tests_run++;
    if (bus.ReserveAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL reserve_x3_waw: got %b expected 0", bus.ReserveAccept);
    end
    step();
    idle_inputs();
    step();
    tests_run++;
    if (bus.BusyCount !== 6'd1) begin
      tests_failed++;
      $display("FAIL reject_no_change: count %0d expected 1", bus.BusyCount);
    end
    set_write(0, 5'd3, 64'h33);
    #1;
    tests_run++;
    if (bus.ReadBusy[0] !== (BYP ? 1'b0 : 1'b1)) begin
      tests_failed++;
      $display("FAIL write_x3_busy_same_cycle: got %b expected %b", bus.ReadBusy[0], (BYP ? 1'b0 : 1'b1));
    end
    step();
    idle_inputs();
    step();
    tests_run++;
    if (bus.BusyCount !== 6'd0 || bus.ReadBusy[0] !== 1'b0 || rd(0) !== 64'h33) begin
      tests_failed++;
      $display("FAIL write_x3_clear: count %0d busy %b data %h expected 0/0/33", bus.BusyCount, bus.ReadBusy[0], rd(0));
    end
    set_reserve(5'd0);
    set_read(1, 5'd0);
    #1;
    tests_run++;
    if (bus.ReserveAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL reserve_x0_accept: got %b expected 1", bus.ReserveAccept);
    end
    step();
    idle_inputs();
    step();
    tests_run++;
    if (bus.BusyCount !== 6'd0 || bus.ReadBusy[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reserve_x0_noeffect: count %0d busy %b expected 0/0", bus.BusyCount, bus.ReadBusy[1]);
    end
  endtask

  task automatic test_reserve_write_same();
    set_read(0, 5'd9);
    set_reserve(5'd9);
    set_write(1, 5'd9, 64'h99);
    #1;
    tests_run++;
    if (bus.ReserveAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsv_wr_free_accept: got %b expected 1", bus.ReserveAccept);
    end
    step();
    idle_inputs();
    step();
    tests_run++;
    if (bus.ReadBusy[0] !== 1'b1 || rd(0) !== 64'h99 || bus.BusyCount !== 6'd1) begin
      tests_failed++;
      $display("FAIL rsv_wr_free_state: busy %b data %h count %0d expected 1/99/1", bus.ReadBusy[0], rd(0), bus.BusyCount);
    end
    set_reserve(5'd9);
    set_write(0, 5'd9, 64'h9A);
    #1;
    tests_run++;
    if (bus.ReserveAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsv_wr_busy_accept: got %b expected 0", bus.ReserveAccept);
    end
    step();
    idle_inputs();
    step();
    tests_run++;
    if (bus.ReadBusy[0] !== 1'b0 || rd(0) !== 64'h9A || bus.BusyCount !== 6'd0) begin
      tests_failed++;
      $display("FAIL rsv_wr_busy_state: busy %b data %h count %0d expected 0/9a/0", bus.ReadBusy[0], rd(0), bus.BusyCount);
    end
  endtask

  task automatic test_bypass();
    set_write(0, 5'd4, 64'h44);
    step();
    idle_inputs();
    set_reserve(5'd4);
    step();
    idle_inputs();
    set_read(1, 5'd4);
    set_write(1, 5'd4, 64'hA5);
    #1;
    tests_run++;
    if (rd(1) !== (BYP ? 64'hA5 : 64'h44)) begin
      tests_failed++;
      $display("FAIL bypass_data: got %h expected %h", rd(1), (BYP ? 64'hA5 : 64'h44));
    end
    tests_run++;
    if (bus.ReadBusy[1] !== (BYP ? 1'b0 : 1'b1)) begin
      tests_failed++;
      $display("FAIL bypass_busy: got %b expected %b", bus.ReadBusy[1], (BYP ? 1'b0 : 1'b1));
    end
    step();
    idle_inputs();
    #1;
    tests_run++;
    if (rd(1) !== 64'hA5 || bus.ReadBusy[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_next_cycle: data %h busy %b expected a5/0", rd(1), bus.ReadBusy[1]);
    end
  endtask

  task automatic test_back_to_back();
    set_write(0, 5'd10, 64'h1010);
    set_write(1, 5'd11, 64'h1111);
    step();
    idle_inputs();
    set_write(0, 5'd12, 64'h1212);
    set_write(1, 5'd13, 64'h1313);
    set_read(0, 5'd10);
    set_read(1, 5'd11);
    #1;
    tests_run++;
    if (rd(0) !== 64'h1010 || rd(1) !== 64'h1111) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h/%h expected 1010/1111", rd(0), rd(1));
    end
    step();
    idle_inputs();
    set_read(0, 5'd12);
    set_read(1, 5'd13);
    #1;
    tests_run++;
    if (rd(0) !== 64'h1212 || rd(1) !== 64'h1313) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h/%h expected 1212/1313", rd(0), rd(1));
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.ReadRegister = '0;
    idle_inputs();
    test_reset();
    test_write_port0();
    test_priority();
    test_reserve();
    test_reserve_write_same();
    test_bypass();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
